// File: rtl/pipe_pkg.sv
// Shared pipeline types for the hazard controller: register width, bypass
// select encoding and the per-stage entry that tracks in-flight instructions.
package pipe_pkg;
   localparam int REG_W = 5;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_MEM = 2'd1;
   localparam logic [1:0] FWD_WB  = 2'd2;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic [REG_W-1:0] rd;
      logic             wr_en;
      logic             is_load;
   } stage_t;

   localparam stage_t STAGE_BUBBLE = '0;

   // The youngest producer wins, so MEM is checked before WB.
   function automatic logic [1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
      if (mem_hit)
         return FWD_MEM;
      else if (wb_hit)
         return FWD_WB;
      else
         return FWD_RF;
   endfunction
endpackage

// File: rtl/reg_match5.sv
// Register index comparator; $r0 is hardwired zero so it never creates a dependency.
module reg_match5
   import pipe_pkg::*;
(
   input  logic [REG_W-1:0] i_a,
   input  logic [REG_W-1:0] i_b,
   output logic             o_match
);
   assign o_match = (i_a == i_b) && (i_a != '0);
endmodule

// File: rtl/hazard_ctrl.sv
// Forwarding/stall controller for the 5-stage pipeline: tracks EX/MEM/WB destinations
// and one multi-cycle mult/div, and produces bypass selects and decode stalls.
module hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MD_LATENCY = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_rs_used,
   input  logic             id_rt_used,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_wr_en,
   input  logic             id_is_load,
   input  logic             id_is_md,
   input  logic             flush,
   output logic             stall,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             md_busy,
   output logic             md_done,
   output logic [REG_W-1:0] md_rd
);
   localparam int CNT_W = $clog2(MD_LATENCY + 1);

   stage_t           r_ex, r_mem, r_wb, w_ex_next;
   logic [CNT_W-1:0] r_md_cnt;
   logic             r_md_done;
   logic [REG_W-1:0] r_md_rd;

   logic w_fa_mem, w_fa_wb, w_fb_mem, w_fb_wb;
   logic w_lu_rs, w_lu_rt;
   logic w_md_rs, w_md_rt, w_md_rd;
   logic w_load_use, w_md_hazard, w_issue;
   logic w_unused;

   reg_match5 u_fa_mem (.i_a(r_ex.rs), .i_b(r_mem.rd), .o_match(w_fa_mem));
   reg_match5 u_fa_wb  (.i_a(r_ex.rs), .i_b(r_wb.rd),  .o_match(w_fa_wb));
   reg_match5 u_fb_mem (.i_a(r_ex.rt), .i_b(r_mem.rd), .o_match(w_fb_mem));
   reg_match5 u_fb_wb  (.i_a(r_ex.rt), .i_b(r_wb.rd),  .o_match(w_fb_wb));
   reg_match5 u_lu_rs  (.i_a(id_rs),   .i_b(r_ex.rd),  .o_match(w_lu_rs));
   reg_match5 u_lu_rt  (.i_a(id_rt),   .i_b(r_ex.rd),  .o_match(w_lu_rt));
   reg_match5 u_md_rs  (.i_a(id_rs),   .i_b(r_md_rd),  .o_match(w_md_rs));
   reg_match5 u_md_rt  (.i_a(id_rt),   .i_b(r_md_rd),  .o_match(w_md_rt));
   reg_match5 u_md_rd  (.i_a(id_rd),   .i_b(r_md_rd),  .o_match(w_md_rd));

   assign md_busy = (r_md_cnt != '0) || r_md_done;
   assign md_done = r_md_done;
   assign md_rd   = r_md_rd;

   assign w_load_use = r_ex.valid & r_ex.is_load & r_ex.wr_en &
                       ((id_rs_used & w_lu_rs) | (id_rt_used & w_lu_rt));
   // The md_done cycle no longer blocks: the datapath bypasses the result into decode.
   assign w_md_hazard = md_busy & ~md_done &
                        (id_is_md | (id_rs_used & w_md_rs) | (id_rt_used & w_md_rt) |
                         (id_wr_en & w_md_rd));

   assign stall   = id_valid & ~flush & (w_load_use | w_md_hazard);
   assign w_issue = id_valid & ~stall & ~flush;

   assign fwd_a_sel = r_ex.valid ? fwd_pick(w_fa_mem & r_mem.valid & r_mem.wr_en,
                                            w_fa_wb  & r_wb.valid  & r_wb.wr_en) : FWD_RF;
   assign fwd_b_sel = r_ex.valid ? fwd_pick(w_fb_mem & r_mem.valid & r_mem.wr_en,
                                            w_fb_wb  & r_wb.valid  & r_wb.wr_en) : FWD_RF;

   always_comb begin
      w_ex_next = STAGE_BUBBLE;
      if (w_issue) begin
         w_ex_next.valid   = 1'b1;
         w_ex_next.rs      = id_rs;
         w_ex_next.rt      = id_rt;
         w_ex_next.rd      = id_rd;
         // Mult/div writes back through its own port, never through the pipe.
         w_ex_next.wr_en   = id_wr_en & ~id_is_md;
         w_ex_next.is_load = id_is_load;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_ex      <= STAGE_BUBBLE;
         r_mem     <= STAGE_BUBBLE;
         r_wb      <= STAGE_BUBBLE;
         r_md_cnt  <= '0;
         r_md_done <= 1'b0;
         r_md_rd   <= '0;
      end else begin
         r_ex      <= w_ex_next;
         r_mem     <= r_ex;
         r_wb      <= r_mem;
         r_md_done <= 1'b0;
         if (w_issue && id_is_md) begin
            r_md_cnt <= CNT_W'(MD_LATENCY - 1);
            r_md_rd  <= id_rd;
         end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - 1'b1;
            if (r_md_cnt == CNT_W'(1))
               r_md_done <= 1'b1;
         end
      end
   end

   assign w_unused = ^{r_mem.rs, r_mem.rt, r_mem.is_load, r_wb.rs, r_wb.rt, r_wb.is_load};
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a short mult/div latency.
module tb_hazard_ctrl;
   logic       clock = 1'b0;
   logic       reset_n;
   logic       id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load, id_is_md, flush;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       stall, md_busy, md_done;
   logic [1:0] fwd_a_sel, fwd_b_sel;
   logic [4:0] md_rd;

   int n_tests = 0;
   int n_fail  = 0;

   hazard_ctrl #(.MD_LATENCY(4)) dut (
      .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr_en(id_wr_en),
      .id_is_load(id_is_load), .id_is_md(id_is_md), .flush(flush), .stall(stall),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .md_busy(md_busy), .md_done(md_done),
      .md_rd(md_rd)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic rsu, input logic rtu, input logic [4:0] rd,
                         input logic wr, input logic ld, input logic md);
      id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
      id_rd = rd; id_wr_en = wr; id_is_load = ld; id_is_md = md;
      #1;
   endtask

   task automatic idle();
      flush = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic drain();
      idle();
      repeat (6) tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      idle();
      tick(); tick();
      reset_n = 1'b1;
      set_id(1, 1, 2, 1, 1, 3, 1, 0, 0);
      n_tests++; if (stall !== 1'b0)     begin n_fail++; $display("FAIL rst_stall got %0d exp 0", stall); end
      n_tests++; if (fwd_a_sel !== 2'd0) begin n_fail++; $display("FAIL rst_fwd_a got %0d exp 0", fwd_a_sel); end
      n_tests++; if (fwd_b_sel !== 2'd0) begin n_fail++; $display("FAIL rst_fwd_b got %0d exp 0", fwd_b_sel); end
      n_tests++; if (md_busy !== 1'b0)   begin n_fail++; $display("FAIL rst_busy got %0d exp 0", md_busy); end
      n_tests++; if (md_done !== 1'b0)   begin n_fail++; $display("FAIL rst_done got %0d exp 0", md_done); end
      n_tests++; if (md_rd !== 5'd0)     begin n_fail++; $display("FAIL rst_md_rd got %0d exp 0", md_rd); end
      drain();
   endtask

   task automatic test_back_to_back();
      set_id(1, 1, 2, 1, 1, 3, 1, 0, 0);
      tick();
      set_id(1, 3, 3, 1, 1, 4, 1, 0, 0);
      n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall got %0d exp 0", stall); end
      tick();
      idle();
      n_tests++; if (fwd_a_sel !== 2'd1) begin n_fail++; $display("FAIL b2b_fwd_a got %0d exp 1", fwd_a_sel); end
      n_tests++; if (fwd_b_sel !== 2'd1) begin n_fail++; $display("FAIL b2b_fwd_b got %0d exp 1", fwd_b_sel); end
      drain();
   endtask

   task automatic test_fwd_wb();
      set_id(1, 1, 2, 1, 1, 5, 1, 0, 0);
      tick();
      idle();
      tick();
      set_id(1, 5, 1, 1, 1, 6, 1, 0, 0);
      tick();
      idle();
      n_tests++; if (fwd_a_sel !== 2'd2) begin n_fail++; $display("FAIL wb_fwd_a got %0d exp 2", fwd_a_sel); end
      n_tests++; if (fwd_b_sel !== 2'd0) begin n_fail++; $display("FAIL wb_fwd_b got %0d exp 0", fwd_b_sel); end
      drain();
      set_id(1, 1, 2, 1, 1, 5, 1, 0, 0);
      tick();
      set_id(1, 2, 3, 1, 1, 5, 1, 0, 0);
      tick();
      set_id(1, 5, 1, 1, 1, 6, 1, 0, 0);
      tick();
      idle();
      n_tests++; if (fwd_a_sel !== 2'd1) begin n_fail++; $display("FAIL mem_wins got %0d exp 1", fwd_a_sel); end
      drain();
   endtask

   task automatic test_load_use();
      set_id(1, 1, 0, 1, 0, 7, 1, 1, 0);
      tick();
      set_id(1, 7, 2, 1, 1, 8, 1, 0, 0);
      n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %0d exp 1", stall); end
      tick();
      n_tests++; if (stall !== 1'b0)     begin n_fail++; $display("FAIL lu_release got %0d exp 0", stall); end
      n_tests++; if (fwd_a_sel !== 2'd0) begin n_fail++; $display("FAIL lu_bubble_fwd got %0d exp 0", fwd_a_sel); end
      tick();
      idle();
      n_tests++; if (fwd_a_sel !== 2'd2) begin n_fail++; $display("FAIL lu_fwd_a got %0d exp 2", fwd_a_sel); end
      n_tests++; if (stall !== 1'b0)     begin n_fail++; $display("FAIL lu_stall_after got %0d exp 0", stall); end
      drain();
   endtask

   task automatic test_r0();
      set_id(1, 0, 0, 1, 1, 0, 1, 1, 0);
      tick();
      set_id(1, 0, 0, 1, 1, 0, 1, 0, 0);
      n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_lu_stall got %0d exp 0", stall); end
      tick();
      set_id(1, 0, 0, 1, 1, 2, 1, 0, 0);
      n_tests++; if (stall !== 1'b0)     begin n_fail++; $display("FAIL r0_stall2 got %0d exp 0", stall); end
      n_tests++; if (fwd_a_sel !== 2'd0) begin n_fail++; $display("FAIL r0_fwd_a1 got %0d exp 0", fwd_a_sel); end
      tick();
      idle();
      n_tests++; if (fwd_a_sel !== 2'd0) begin n_fail++; $display("FAIL r0_fwd_a2 got %0d exp 0", fwd_a_sel); end
      n_tests++; if (fwd_b_sel !== 2'd0) begin n_fail++; $display("FAIL r0_fwd_b2 got %0d exp 0", fwd_b_sel); end
      drain();
   endtask

   task automatic test_md();
      int n;
      set_id(1, 1, 2, 1, 1, 9, 1, 0, 1);
      n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL md_issue_stall got %0d exp 0", stall); end
      tick();
      set_id(1, 9, 0, 1, 1, 10, 1, 0, 0);
      n_tests++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL md_busy1 got %0d exp 1", md_busy); end
      n_tests++; if (md_rd !== 5'd9)   begin n_fail++; $display("FAIL md_rd1 got %0d exp 9", md_rd); end
      n = 0;
      while (stall === 1'b1 && n < 10) begin
         n++;
         tick();
      end
      n_tests++; if (n != 3)           begin n_fail++; $display("FAIL md_stall_cycles got %0d exp 3", n); end
      n_tests++; if (md_done !== 1'b1) begin n_fail++; $display("FAIL md_done got %0d exp 1", md_done); end
      n_tests++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL md_busy_done got %0d exp 1", md_busy); end
      tick();
      idle();
      n_tests++; if (md_busy !== 1'b0)   begin n_fail++; $display("FAIL md_busy_end got %0d exp 0", md_busy); end
      n_tests++; if (md_done !== 1'b0)   begin n_fail++; $display("FAIL md_done_end got %0d exp 0", md_done); end
      n_tests++; if (md_rd !== 5'd9)     begin n_fail++; $display("FAIL md_rd_hold got %0d exp 9", md_rd); end
      n_tests++; if (fwd_a_sel !== 2'd0) begin n_fail++; $display("FAIL md_no_pipe_fwd got %0d exp 0", fwd_a_sel); end
      drain();
      set_id(1, 1, 2, 1, 1, 11, 1, 0, 1);
      tick();
      set_id(1, 3, 4, 1, 1, 12, 1, 0, 1);
      n = 0;
      while (stall === 1'b1 && n < 10) begin
         n++;
         tick();
      end
      n_tests++; if (n != 3) begin n_fail++; $display("FAIL md2_stall_cycles got %0d exp 3", n); end
      tick();
      idle();
      n_tests++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL md2_busy got %0d exp 1", md_busy); end
      n_tests++; if (md_rd !== 5'd12)  begin n_fail++; $display("FAIL md2_rd got %0d exp 12", md_rd); end
      n_tests++; if (md_done !== 1'b0) begin n_fail++; $display("FAIL md2_done got %0d exp 0", md_done); end
      drain();
   endtask

   task automatic test_flush_reset();
      logic seen_done;
      set_id(1, 1, 0, 1, 0, 7, 1, 1, 0);
      tick();
      flush = 1'b1;
      set_id(1, 7, 2, 1, 1, 8, 1, 0, 0);
      n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %0d exp 0", stall); end
      tick();
      idle();
      n_tests++; if (fwd_a_sel !== 2'd0) begin n_fail++; $display("FAIL flush_bubble got %0d exp 0", fwd_a_sel); end
      drain();
      set_id(1, 1, 2, 1, 1, 13, 1, 0, 1);
      tick();
      idle();
      n_tests++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL rmul_busy got %0d exp 1", md_busy); end
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      #1;
      n_tests++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL rmul_busy_clr got %0d exp 0", md_busy); end
      n_tests++; if (md_rd !== 5'd0)   begin n_fail++; $display("FAIL rmul_rd_clr got %0d exp 0", md_rd); end
      seen_done = 1'b0;
      repeat (6) begin
         tick();
         if (md_done === 1'b1) seen_done = 1'b1;
      end
      n_tests++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL rmul_silent got %0d exp 0", seen_done); end
   endtask

   initial begin
      reset_n = 1'b0;
      idle();
      test_reset();
      test_back_to_back();
      test_fwd_wb();
      test_load_use();
      test_r0();
      test_md();
      test_flush_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
